dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single 8-bit data memory port: requester A (processor load/store unit) and requester B (loader/DMA).
- Grants at most one access per cycle, round-robin between A and B.
- Supports locked bursts, so one requester can own the port for up to MAX_BURST consecutive beats.
- Drives the memory's address, read-enable, write-enable and write-data; registers read data back to the winning requester.

Parameters:
- MAX_BURST, 4, maximum consecutive granted beats per locked ownership. Legal range 1..15; 1 disables locking.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- a_req  in  1  A requests an access this cycle
- a_we  in  1  1 = write, 0 = read
- a_lock  in  1  A wants to keep the port after this beat
- a_addr  in  8  A address
- a_wdata  in  8  A write data
- a_gnt  out  1  A's access is performed this cycle (combinational)
- a_rvalid  out  1  a_rdata valid (registered)
- a_rdata  out  8  read data for A's last granted read
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- mem_addr  out  8  memory address
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory combinational read data

Behaviour:
- State register: IDLE, OWN_A, OWN_B. Round-robin pointer ptr (0 = A preferred). Burst counter beat_cnt, 4 bits.
- Reset (synchronous) sets:
  - state = IDLE, ptr = A, beat_cnt = 0
  - a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0
- Reset cycle: all gnt = 0 and mem_read = mem_write = 0, regardless of requests. Reset mid-burst abandons ownership.
- Arbitration in IDLE is combinational in cycle t:
  - Only one requester active: that requester wins.
  - Both active: the ptr side wins.
  - None active: no grant.
- Winner W:
  - W_gnt = 1.
  - mem_addr = W_addr, mem_wdata = W_wdata.
  - mem_write = W_we, mem_read = ~W_we.
- No grant:
  - mem_read = mem_write = 0.
  - mem_addr and mem_wdata = 0.
- Write timing: a granted write commits at the posedge ending cycle t.
- Read timing:
  - A granted read captures mem_rdata into W_rdata at the posedge ending cycle t.
  - W_rvalid = 1 in cycle t+1 only; it is a single-cycle pulse and is 0 after a write grant.
  - The loser's rdata holds its previous value; the loser's rvalid = 0.
- Grant without lock (W_lock = 0, or MAX_BURST = 1): ptr goes to the other requester; state stays IDLE.
- Grant with lock (W_lock = 1, MAX_BURST > 1): state goes to OWN_W, beat_cnt = 1; ptr is unchanged.
- OWN_W, when W_req = 1:
  - W is granted regardless of the other requester's req.
  - beat_cnt increments.
  - If W_lock = 0 on this beat, or beat_cnt reaches MAX_BURST after the increment: state goes to IDLE, ptr = other, beat_cnt = 0.
- OWN_W, when W_req = 0:
  - Ownership is dropped in the same cycle.
  - The cycle is arbitrated as IDLE with the other side preferred; ptr = other before the decision.
  - The other requester is granted the same cycle if it is requesting.
- Requester rule: req, we, addr, wdata and lock must be held stable until gnt is seen. A requester may change inputs in the cycle after gnt.
- Invariants:
  - a_gnt and b_gnt are never both 1.
  - mem_read and mem_write are never both 1.
  - Outside a locked burst, a requester that is continuously requesting waits at most one granted cycle of the other requester.
  - During a burst it waits at most MAX_BURST cycles.

Test Plan:
- Reset, then a_req=1, a_we=1, a_addr=8'h10, a_wdata=8'h5A for 1 cycle; then a_we=0 read of 8'h10 -> a_gnt=1 both cycles, mem_write=1 then mem_read=1, a_rvalid=1 with a_rdata=8'h5A the cycle after the read grant.
- a_req and b_req both held high with reads, no lock, for 6 cycles -> grants alternate A,B,A,B,A,B. mem_addr alternates between a_addr and b_addr. Each rvalid pulses one cycle after its gnt.
- b_lock=1 with b_req=1 for 6 writes to addresses 0..5, a_req=1 throughout, MAX_BURST=4 -> B granted addresses 0..3 on 4 consecutive cycles, then A granted, then B granted address 4.
- B in OWN_B after 2 beats drops b_req while a_req=1 -> A granted in that same cycle, state returns to IDLE.
- Reset asserted during a B locked burst with both requesting -> gnt=0, mem_read=mem_write=0, rvalid=0 that cycle. After release, A wins the first contested cycle (ptr=A).
- No requests for 3 cycles -> mem_read=mem_write=0, both gnt=0, both rvalid=0; rdata values hold their previous contents.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the shared data-memory port.
// The arbiter takes the slave view; requesters and memory model take the master view.
interface dmem_arbiter_if;
   logic       a_req, a_we, a_lock;
   logic [7:0] a_addr, a_wdata;
   logic       a_gnt, a_rvalid;
   logic [7:0] a_rdata;

   logic       b_req, b_we, b_lock;
   logic [7:0] b_addr, b_wdata;
   logic       b_gnt, b_rvalid;
   logic [7:0] b_rdata;

   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_read, mem_write;

   modport slave (
      input  a_req, a_we, a_lock, a_addr, a_wdata,
      output a_gnt, a_rvalid, a_rdata,
      input  b_req, b_we, b_lock, b_addr, b_wdata,
      output b_gnt, b_rvalid, b_rdata,
      output mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_rdata
   );

   modport master (
      output a_req, a_we, a_lock, a_addr, a_wdata,
      input  a_gnt, a_rvalid, a_rdata,
      output b_req, b_we, b_lock, b_addr, b_wdata,
      input  b_gnt, b_rvalid, b_rdata,
      input  mem_addr, mem_wdata, mem_read, mem_write,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter for the 8-bit data memory port with locked bursts.
// Grant is combinational in the request cycle; read data returns registered one cycle later.
module dmem_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         reset,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

   localparam logic [3:0] MAX_B   = 4'(MAX_BURST);
   localparam bit         LOCK_EN = (MAX_BURST > 1);

   state_e     state_q, state_d;
   logic       ptr_q, ptr_d;
   logic [3:0] beat_cnt_q, beat_cnt_d;
   logic       a_rvalid_q, b_rvalid_q;
   logic [7:0] a_rdata_q, b_rdata_q;

   logic       gnt_a, gnt_b, arb, pref;
   logic [3:0] cnt_inc;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      beat_cnt_d = beat_cnt_q;
      gnt_a      = 1'b0;
      gnt_b      = 1'b0;
      arb        = 1'b0;
      pref       = ptr_q;
      cnt_inc    = beat_cnt_q + 4'd1;

      case (state_q)
         OWN_A: begin
            if (bus.a_req) begin
               gnt_a = 1'b1;
               if (!bus.a_lock || cnt_inc >= MAX_B) begin
                  state_d    = IDLE;
                  ptr_d      = 1'b1;
                  beat_cnt_d = 4'd0;
               end else begin
                  beat_cnt_d = cnt_inc;
               end
            end else begin
               arb  = 1'b1;
               pref = 1'b1;
            end
         end
         OWN_B: begin
            if (bus.b_req) begin
               gnt_b = 1'b1;
               if (!bus.b_lock || cnt_inc >= MAX_B) begin
                  state_d    = IDLE;
                  ptr_d      = 1'b0;
                  beat_cnt_d = 4'd0;
               end else begin
                  beat_cnt_d = cnt_inc;
               end
            end else begin
               arb  = 1'b1;
               pref = 1'b0;
            end
         end
         default: arb = 1'b1;
      endcase

      // An owner that stops requesting is treated as if the port were idle,
      // with the other side preferred, so the hand-over costs no cycle.
      if (arb) begin
         state_d    = IDLE;
         ptr_d      = pref;
         beat_cnt_d = 4'd0;
         if (bus.a_req && (!bus.b_req || !pref)) begin
            gnt_a = 1'b1;
            if (bus.a_lock && LOCK_EN) begin
               state_d    = OWN_A;
               beat_cnt_d = 4'd1;
            end else begin
               ptr_d = 1'b1;
            end
         end else if (bus.b_req) begin
            gnt_b = 1'b1;
            if (bus.b_lock && LOCK_EN) begin
               state_d    = OWN_B;
               beat_cnt_d = 4'd1;
            end else begin
               ptr_d = 1'b0;
            end
         end
      end

      if (reset) begin
         gnt_a = 1'b0;
         gnt_b = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= 1'b0;
         beat_cnt_q <= 4'd0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= 8'd0;
         b_rdata_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         beat_cnt_q <= beat_cnt_d;
         a_rvalid_q <= gnt_a && !bus.a_we;
         b_rvalid_q <= gnt_b && !bus.b_we;
         if (gnt_a && !bus.a_we) a_rdata_q <= bus.mem_rdata;
         if (gnt_b && !bus.b_we) b_rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.a_gnt     = gnt_a;
   assign bus.b_gnt     = gnt_b;
   assign bus.a_rvalid  = a_rvalid_q;
   assign bus.b_rvalid  = b_rvalid_q;
   assign bus.a_rdata   = a_rdata_q;
   assign bus.b_rdata   = b_rdata_q;

   assign bus.mem_addr  = gnt_a ? bus.a_addr  : (gnt_b ? bus.b_addr  : 8'd0);
   assign bus.mem_wdata = gnt_a ? bus.a_wdata : (gnt_b ? bus.b_wdata : 8'd0);
   assign bus.mem_write = (gnt_a && bus.a_we)  || (gnt_b && bus.b_we);
   assign bus.mem_read  = (gnt_a && !bus.a_we) || (gnt_b && !bus.b_we);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256-byte memory model; unwritten locations read as ~addr.
module tb_dmem_arbiter;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_miss;
   logic [7:0] mem [256];

   dmem_arbiter_if bus();

   dmem_arbiter #(.MAX_BURST(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_addr];
   always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic set_a(input logic req, input logic we, input logic lock,
                        input logic [7:0] addr, input logic [7:0] wdata);
      bus.a_req = req; bus.a_we = we; bus.a_lock = lock; bus.a_addr = addr; bus.a_wdata = wdata;
   endtask

   task automatic set_b(input logic req, input logic we, input logic lock,
                        input logic [7:0] addr, input logic [7:0] wdata);
      bus.b_req = req; bus.b_we = we; bus.b_lock = lock; bus.b_addr = addr; bus.b_wdata = wdata;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      chk("gnt_mutex", 32'(bus.a_gnt && bus.b_gnt), 0);
      chk("rw_mutex", 32'(bus.mem_read && bus.mem_write), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sample();
      chk("rst_a_gnt", 32'(bus.a_gnt), 0);
      chk("rst_b_gnt", 32'(bus.b_gnt), 0);
      next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
      reset = 1'b1;
      set_a(1, 0, 0, 8'h40, 8'h00);
      set_b(1, 1, 1, 8'h07, 8'h87);

      // reset cycle with both requesting
      sample();
      chk("rst_a_gnt", 32'(bus.a_gnt), 0);
      chk("rst_b_gnt", 32'(bus.b_gnt), 0);
      chk("rst_mem_read", 32'(bus.mem_read), 0);
      chk("rst_mem_write", 32'(bus.mem_write), 0);
      next_cycle();
      reset = 1'b0;
      set_a(0, 0, 0, 8'h00, 8'h00);
      set_b(0, 0, 0, 8'h00, 8'h00);
      sample();
      chk("rst_a_rvalid", 32'(bus.a_rvalid), 0);
      chk("rst_b_rvalid", 32'(bus.b_rvalid), 0);
      chk("rst_a_rdata", 32'(bus.a_rdata), 0);
      chk("rst_b_rdata", 32'(bus.b_rdata), 0);
      next_cycle();

      // write then read back by A
      set_a(1, 1, 0, 8'h10, 8'h5A);
      sample();
      chk("wr_a_gnt", 32'(bus.a_gnt), 1);
      chk("wr_mem_write", 32'(bus.mem_write), 1);
      chk("wr_mem_addr", 32'(bus.mem_addr), 32'h10);
      chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'h5A);
      next_cycle();
      set_a(1, 0, 0, 8'h10, 8'h00);
      sample();
      chk("rd_a_gnt", 32'(bus.a_gnt), 1);
      chk("rd_mem_read", 32'(bus.mem_read), 1);
      chk("rd_mem_write", 32'(bus.mem_write), 0);
      chk("rd_a_rvalid_after_wr", 32'(bus.a_rvalid), 0);
      next_cycle();
      set_a(0, 0, 0, 8'h00, 8'h00);
      sample();
      chk("rd_a_rvalid", 32'(bus.a_rvalid), 1);
      chk("rd_a_rdata", 32'(bus.a_rdata), 32'h5A);
      chk("rd_a_gnt_idle", 32'(bus.a_gnt), 0);
      next_cycle();

      // contested unlocked reads alternate starting with A
      do_reset();
      set_a(1, 0, 0, 8'h20, 8'h00);
      set_b(1, 0, 0, 8'h30, 8'h00);
      for (int i = 0; i < 6; i++) begin
         sample();
         chk("rr_a_gnt", 32'(bus.a_gnt), 32'((i % 2) == 0));
         chk("rr_b_gnt", 32'(bus.b_gnt), 32'((i % 2) == 1));
         chk("rr_mem_addr", 32'(bus.mem_addr), (i % 2 == 0) ? 32'h20 : 32'h30);
         chk("rr_a_rvalid", 32'(bus.a_rvalid), 32'((i % 2) == 1));
         chk("rr_b_rvalid", 32'(bus.b_rvalid), 32'(i > 0 && (i % 2) == 0));
         if (i > 0) chk("rr_rdata", (i % 2 == 1) ? 32'(bus.a_rdata) : 32'(bus.b_rdata),
                        (i % 2 == 1) ? 32'hDF : 32'hCF);
         next_cycle();
      end
      set_a(0, 0, 0, 8'h00, 8'h00);
      set_b(0, 0, 0, 8'h00, 8'h00);
      sample();
      chk("rr_tail_b_rvalid", 32'(bus.b_rvalid), 1);
      chk("rr_tail_b_rdata", 32'(bus.b_rdata), 32'hCF);
      chk("rr_tail_a_rvalid", 32'(bus.a_rvalid), 0);
      next_cycle();

      // lone A access moves the pointer to B
      set_a(1, 0, 0, 8'h40, 8'h00);
      sample();
      chk("pre_a_gnt", 32'(bus.a_gnt), 1);
      next_cycle();

      // B locked burst of writes with A contending
      set_b(1, 1, 1, 8'h00, 8'h80);
      for (int k = 0; k < 4; k++) begin
         sample();
         chk("burst_b_gnt", 32'(bus.b_gnt), 1);
         chk("burst_a_gnt", 32'(bus.a_gnt), 0);
         chk("burst_mem_addr", 32'(bus.mem_addr), 32'(k));
         chk("burst_mem_write", 32'(bus.mem_write), 1);
         chk("burst_mem_wdata", 32'(bus.mem_wdata), 32'h80 + 32'(k));
         next_cycle();
         set_b(1, 1, 1, 8'(k + 1), 8'h81 + 8'(k));
      end
      sample();
      chk("burst_end_a_gnt", 32'(bus.a_gnt), 1);
      chk("burst_end_b_gnt", 32'(bus.b_gnt), 0);
      chk("burst_end_mem_addr", 32'(bus.mem_addr), 32'h40);
      chk("burst_end_mem_read", 32'(bus.mem_read), 1);
      next_cycle();
      sample();
      chk("burst2_b_gnt", 32'(bus.b_gnt), 1);
      chk("burst2_mem_addr", 32'(bus.mem_addr), 32'h04);
      chk("burst2_a_rvalid", 32'(bus.a_rvalid), 1);
      chk("burst2_a_rdata", 32'(bus.a_rdata), 32'hBF);
      next_cycle();
      set_b(1, 1, 1, 8'h05, 8'h85);
      sample();
      chk("burst2_beat2_b_gnt", 32'(bus.b_gnt), 1);
      chk("burst2_beat2_a_gnt", 32'(bus.a_gnt), 0);
      next_cycle();

      // owner drops request: A takes the port the same cycle
      set_b(0, 0, 0, 8'h00, 8'h00);
      sample();
      chk("drop_a_gnt", 32'(bus.a_gnt), 1);
      chk("drop_b_gnt", 32'(bus.b_gnt), 0);
      chk("drop_mem_read", 32'(bus.mem_read), 1);
      chk("drop_mem_addr", 32'(bus.mem_addr), 32'h40);
      next_cycle();
      set_b(1, 0, 0, 8'h02, 8'h00);
      sample();
      chk("post_drop_b_gnt", 32'(bus.b_gnt), 1);
      chk("post_drop_mem_addr", 32'(bus.mem_addr), 32'h02);
      next_cycle();

      // start a B lock, then reset in the middle of it
      set_a(0, 0, 0, 8'h00, 8'h00);
      set_b(1, 1, 1, 8'h06, 8'h86);
      sample();
      chk("lock_b_gnt", 32'(bus.b_gnt), 1);
      chk("burst_rdback_b_rvalid", 32'(bus.b_rvalid), 1);
      chk("burst_rdback_b_rdata", 32'(bus.b_rdata), 32'h82);
      next_cycle();
      reset = 1'b1;
      set_a(1, 0, 0, 8'h40, 8'h00);
      set_b(1, 1, 1, 8'h07, 8'h87);
      sample();
      chk("midrst_a_gnt", 32'(bus.a_gnt), 0);
      chk("midrst_b_gnt", 32'(bus.b_gnt), 0);
      chk("midrst_mem_read", 32'(bus.mem_read), 0);
      chk("midrst_mem_write", 32'(bus.mem_write), 0);
      chk("midrst_a_rvalid", 32'(bus.a_rvalid), 0);
      chk("midrst_b_rvalid", 32'(bus.b_rvalid), 0);
      next_cycle();
      reset = 1'b0;
      sample();
      chk("postrst_a_gnt", 32'(bus.a_gnt), 1);
      chk("postrst_b_gnt", 32'(bus.b_gnt), 0);
      chk("postrst_b_rdata", 32'(bus.b_rdata), 0);
      chk("postrst_b_rvalid", 32'(bus.b_rvalid), 0);
      next_cycle();

      // idle port
      set_a(0, 0, 0, 8'h00, 8'h00);
      set_b(0, 0, 0, 8'h00, 8'h00);
      sample();
      chk("idle_a_rvalid_last", 32'(bus.a_rvalid), 1);
      chk("idle_a_rdata_last", 32'(bus.a_rdata), 32'hBF);
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         sample();
         chk("idle_a_gnt", 32'(bus.a_gnt), 0);
         chk("idle_b_gnt", 32'(bus.b_gnt), 0);
         chk("idle_mem_read", 32'(bus.mem_read), 0);
         chk("idle_mem_write", 32'(bus.mem_write), 0);
         chk("idle_mem_addr", 32'(bus.mem_addr), 0);
         chk("idle_a_rvalid", 32'(bus.a_rvalid), 0);
         chk("idle_b_rvalid", 32'(bus.b_rvalid), 0);
         chk("idle_a_rdata", 32'(bus.a_rdata), 32'hBF);
         chk("idle_b_rdata", 32'(bus.b_rdata), 0);
         next_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
